// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arb_pkg
// Purpose  : Shared types, grant encodings and the packet-level selection
//            function for the Ethernet TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package eth_tx_arb_pkg;

  // Arbiter phases: waiting for a decision, forwarding a packet, gap idle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // One-hot owner encoding driven on the grant output
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_ROCE = 2'b01;
  localparam logic [1:0] GNT_CM   = 2'b10;

  // Picks the next owner from the valid pair. rr_cm set means req 1 is the
  // favoured side in round-robin mode. In strict mode req 1 wins until it has
  // taken max_burst grants in a row while req 0 was also asking.
  function automatic logic [1:0] arb_select(
    input logic       v0,
    input logic       v1,
    input logic       rr_cm,
    input logic       strict,
    input logic [7:0] burst,
    input logic [7:0] max_burst
  );
    logic [1:0] g;
    g = GNT_NONE;
    if (v0 && v1) begin
      if (strict) g = (burst == max_burst) ? GNT_ROCE : GNT_CM;
      else        g = rr_cm ? GNT_CM : GNT_ROCE;
    end else if (v0) begin
      g = GNT_ROCE;
    end else if (v1) begin
      g = GNT_CM;
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Purpose  : Packet-level arbiter sharing one CMAC TX AXI-Stream between the
//            RoCE stream (req 0) and the CM reply stream (req 1). Never
//            interleaves packets, honours PFC pause at packet boundaries and
//            inserts a programmable inter-packet gap.
// Options  : ETH_TX_ARB_STAT_EN adds packet and pause-cycle statistics.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 512,
  parameter int CM_MAX_BURST      = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                           s0_axis_tvalid,
  input  logic                           s0_axis_tlast,
  output logic                           s0_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                           s1_axis_tvalid,
  input  logic                           s1_axis_tlast,
  output logic                           s1_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  input  logic [7:0]                     stat_rx_pause_req,
  input  logic [7:0]                     cfg_pause_mask,
  input  logic                           cfg_cm_strict,
  input  logic [15:0]                    cfg_gap_cycles,
  output logic [1:0]                     grant,
  output logic                           tx_busy
`ifdef ETH_TX_ARB_STAT_EN
  ,
  output logic [31:0]                    stat_pkt_cnt0,
  output logic [31:0]                    stat_pkt_cnt1,
  output logic [31:0]                    stat_pause_cycles
`endif
);

  localparam logic [7:0] BURST_MAX = 8'(CM_MAX_BURST);

  arb_state_t  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_cm_q, rr_cm_d;   // 1: req 1 favoured on the next tie
  logic [7:0]  burst_q, burst_d;   // consecutive req-1 grants, saturating
  logic [15:0] gap_q,   gap_d;

  logic        paused;
  logic [1:0]  sel;
  logic        last_hs;

  assign paused  = |(stat_rx_pause_req & cfg_pause_mask);
  assign sel     = arb_select(s0_axis_tvalid, s1_axis_tvalid, rr_cm_q,
                              cfg_cm_strict, burst_q, BURST_MAX);
  assign last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  assign grant   = grant_q;
  assign tx_busy = (state_q == XFER) || (state_q == GAP);

  // Zero-latency pass-through of the owning stream; everything idles otherwise
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state_q == XFER) begin
      if (grant_q == GNT_ROCE) begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end else if (grant_q == GNT_CM) begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end
    end
  end

  // Next-state: grant decision in IDLE, packet end in XFER, gap countdown
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_cm_d = rr_cm_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (!paused && (sel != GNT_NONE)) begin
          state_d = XFER;
          grant_d = sel;
          rr_cm_d = (sel == GNT_ROCE);
          if (sel == GNT_ROCE)          burst_d = 8'd0;
          else if (burst_q < BURST_MAX) burst_d = burst_q + 8'd1;
        end
      end
      XFER: begin
        if (last_hs) begin
          grant_d = GNT_NONE;
          if (cfg_gap_cycles == 16'd0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = cfg_gap_cycles;
          end
        end
      end
      GAP: begin
        // Leave on the cycle the counter shows 1 so exactly cfg_gap_cycles
        // cycles are spent here
        if (gap_q <= 16'd1) begin
          state_d = IDLE;
          gap_d   = 16'd0;
        end else begin
          gap_d   = gap_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // State and arbitration bookkeeping registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      rr_cm_q <= 1'b0;
      burst_q <= 8'd0;
      gap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_cm_q <= rr_cm_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

`ifdef ETH_TX_ARB_STAT_EN
  logic [31:0] pkt_cnt0_q, pkt_cnt1_q, pause_cyc_q;

  // Free-running statistics, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt0_q  <= 32'd0;
      pkt_cnt1_q  <= 32'd0;
      pause_cyc_q <= 32'd0;
    end else begin
      if (state_q == XFER && last_hs && grant_q == GNT_ROCE)
        pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
      if (state_q == XFER && last_hs && grant_q == GNT_CM)
        pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
      if (state_q == IDLE && paused && (s0_axis_tvalid || s1_axis_tvalid))
        pause_cyc_q <= pause_cyc_q + 32'd1;
    end
  end

  assign stat_pkt_cnt0     = pkt_cnt0_q;
  assign stat_pkt_cnt1     = pkt_cnt1_q;
  assign stat_pause_cycles = pause_cyc_q;
`else
  // Statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_arbiter
// Purpose  : Self-checking bench for eth_tx_arbiter: packet-level reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

  localparam int W    = 512;
  localparam int K    = W / 8;
  localparam int MAXB = 4;
  localparam logic [K-1:0] KEEP_ALL = {K{1'b1}};

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] s_tdata  [2];
  logic [K-1:0] s_tkeep  [2];
  logic         s_tvalid [2];
  logic         s_tlast  [2];
  logic         s0_tready, s1_tready;
  logic [W-1:0] m_axis_tdata;
  logic [K-1:0] m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tlast;
  logic         m_axis_tready = 1'b0;
  logic [7:0]   stat_rx_pause_req = 8'h00;
  logic [7:0]   cfg_pause_mask = 8'h00;
  logic         cfg_cm_strict = 1'b0;
  logic [15:0]  cfg_gap_cycles = 16'd0;
  logic [1:0]   grant;
  logic         tx_busy;
`ifdef ETH_TX_ARB_STAT_EN
  logic [31:0]  stat_pkt_cnt0, stat_pkt_cnt1, stat_pause_cycles;
`endif

  eth_tx_arbiter #(.C_AXIS_DATA_WIDTH(W), .CM_MAX_BURST(MAXB)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .s0_axis_tdata     (s_tdata[0]),
    .s0_axis_tkeep     (s_tkeep[0]),
    .s0_axis_tvalid    (s_tvalid[0]),
    .s0_axis_tlast     (s_tlast[0]),
    .s0_axis_tready    (s0_tready),
    .s1_axis_tdata     (s_tdata[1]),
    .s1_axis_tkeep     (s_tkeep[1]),
    .s1_axis_tvalid    (s_tvalid[1]),
    .s1_axis_tlast     (s_tlast[1]),
    .s1_axis_tready    (s1_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .stat_rx_pause_req (stat_rx_pause_req),
    .cfg_pause_mask    (cfg_pause_mask),
    .cfg_cm_strict     (cfg_cm_strict),
    .cfg_gap_cycles    (cfg_gap_cycles),
    .grant             (grant),
    .tx_busy           (tx_busy)
`ifdef ETH_TX_ARB_STAT_EN
    ,
    .stat_pkt_cnt0     (stat_pkt_cnt0),
    .stat_pkt_cnt1     (stat_pkt_cnt1),
    .stat_pause_cycles (stat_pause_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs, applied to the DUT pins only inside drive()
  int         vprob[2];
  int         rprob = 100;
  int         ready_mode = 0;
  logic       tog = 1'b1;
  int         fixed_len = 3;
  bit         rand_cfg = 0;
  logic       strict_v = 1'b0;
  logic [15:0] gap_v = 16'd0;
  logic [7:0] pause_v = 8'h00;
  logic [7:0] mask_v = 8'h00;

  // Source packet state
  int pk_num[2], pk_beat[2], pk_len[2];

  // Reference model: who owns the link, gap cycles left, tie-break state
  int m_owner, m_cool, m_rr, m_burst;

  // Observations
  int   gseq[$], mseq[$], runs[$];
  logic [W-1:0] outq[$];
  logic [1:0] prev_grant;
  bit   after_last;
  int   zr, tlast_cnt;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_data(int s, int n, int b);
    logic [W-1:0] d;
    for (int i = 0; i < W/32; i++)
      d[i*32 +: 32] = 32'(s*32'h1000_0000 + n*32'h0001_0000 + b*32'h100 + i) ^ 32'h5A5A_0000;
    return d;
  endfunction

  function automatic int new_len();
    return (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cool = 0; m_rr = 0; m_burst = 0;
    for (int s = 0; s < 2; s++) begin
      pk_num[s] = 0; pk_beat[s] = 0; pk_len[s] = new_len();
      s_tvalid[s] = 1'b0; s_tlast[s] = 1'b0;
      s_tdata[s] = '0; s_tkeep[s] = '0;
    end
    gseq.delete(); mseq.delete(); runs.delete(); outq.delete();
    prev_grant = 2'b00; after_last = 0; zr = 0; tlast_cnt = 0;
  endtask

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      s_tvalid[s] = (int'($urandom_range(99)) < vprob[s]);
      s_tdata[s]  = beat_data(s, pk_num[s], pk_beat[s]);
      s_tlast[s]  = (pk_beat[s] == pk_len[s] - 1);
      s_tkeep[s]  = s_tlast[s] ? (KEEP_ALL >> (pk_num[s] % 8)) : KEEP_ALL;
    end
    if (ready_mode == 1) begin
      m_axis_tready = tog;
      tog = ~tog;
    end else begin
      m_axis_tready = (int'($urandom_range(99)) < rprob);
    end
    if (rand_cfg) begin
      if ($urandom_range(99) < 5)  strict_v = 1'($urandom_range(1));
      if ($urandom_range(99) < 5)  gap_v    = 16'($urandom_range(3));
      if ($urandom_range(99) < 10) pause_v  = 8'($urandom) & 8'($urandom);
      if ($urandom_range(99) < 2)  mask_v   = 8'($urandom);
    end
    cfg_cm_strict     = strict_v;
    cfg_gap_cycles    = gap_v;
    stat_rx_pause_req = pause_v;
    cfg_pause_mask    = mask_v;
  endtask

  // Compare DUT against the model, then advance model and sources to what the
  // coming clock edge does
  task automatic check_cycle();
    logic [W-1:0] ed;
    logic [K-1:0] ek;
    logic ev, el, er0, er1, eb;
    logic [1:0] eg;
    int w;
    ed = '0; ek = '0; ev = 0; el = 0; er0 = 0; er1 = 0; eg = 2'b00;
    eb = (m_owner >= 0) || (m_cool > 0);
    if (m_owner >= 0) begin
      ed = s_tdata[m_owner]; ek = s_tkeep[m_owner];
      ev = s_tvalid[m_owner]; el = s_tlast[m_owner];
      if (m_owner == 0) begin er0 = m_axis_tready; eg = 2'b01; end
      else              begin er1 = m_axis_tready; eg = 2'b10; end
    end
    chk("m_tvalid", m_axis_tvalid, ev);
    chk("s0_tready", s0_tready, er0);
    chk("s1_tready", s1_tready, er1);
    chk("grant", grant, eg);
    chk("tx_busy", tx_busy, eb);
    if (ev) begin
      chk("m_tdata", m_axis_tdata, ed);
      chk("m_tkeep", m_axis_tkeep, ek);
      chk("m_tlast", m_axis_tlast, el);
    end

    // DUT-side observations for the directed literal checks
    if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant == 2'b10 ? 1 : 0);
    prev_grant = grant;
    if (after_last) begin
      if (m_axis_tvalid) begin runs.push_back(zr); after_last = 0; end
      else zr++;
    end
    if (m_axis_tvalid && m_axis_tready) outq.push_back(m_axis_tdata);
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      after_last = 1; zr = 0; tlast_cnt++;
    end

    // Model: packet owner keeps the link until its tlast is accepted
    if (m_owner >= 0) begin
      if (s_tvalid[m_owner] && m_axis_tready && s_tlast[m_owner]) begin
        m_owner = -1;
        m_cool  = int'(cfg_gap_cycles);
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (((stat_rx_pause_req & cfg_pause_mask) == 8'h00) &&
                 (s_tvalid[0] || s_tvalid[1])) begin
      if (s_tvalid[0] && s_tvalid[1])
        w = cfg_cm_strict ? ((m_burst == MAXB) ? 0 : 1) : m_rr;
      else
        w = s_tvalid[0] ? 0 : 1;
      m_owner = w;
      m_rr    = 1 - w;
      m_burst = (w == 0) ? 0 : ((m_burst < MAXB) ? m_burst + 1 : MAXB);
      mseq.push_back(w);
    end

    // Sources react to the ready the DUT actually gave them
    for (int s = 0; s < 2; s++) begin
      if (s_tvalid[s] && ((s == 0) ? s0_tready : s1_tready)) begin
        if (s_tlast[s]) begin
          pk_num[s]++; pk_beat[s] = 0; pk_len[s] = new_len();
        end else begin
          pk_beat[s]++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int exp_rr[4];
    int exp_st[10];
    int t0;
    exp_rr = '{0, 1, 0, 1};
    exp_st = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    vprob = '{100, 100};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", m_axis_tvalid, 1'b0);
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_tready", {s0_tready, s1_tready}, 2'b00);
    #1 rstn = 1'b1;

    // Round-robin contention, 3-beat packets, no gap
    fixed_len = 3; model_reset();
    repeat (30) step();
    chk("rr_count", gseq.size() >= 4, 1'b1);
    if (gseq.size() >= 4 && mseq.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("rr_dut_seq", gseq[i], exp_rr[i]);
        chk("rr_model_seq", mseq[i], exp_rr[i]);
      end
    if (runs.size() >= 2) begin
      chk("rr_bubble0", runs[0], 1);
      chk("rr_bubble1", runs[1], 1);
    end

    // Strict mode starvation bound
    fixed_len = 1; strict_v = 1'b1; do_reset();
    repeat (40) step();
    chk("strict_count", gseq.size() >= 10, 1'b1);
    if (gseq.size() >= 10 && mseq.size() >= 10)
      for (int i = 0; i < 10; i++) begin
        chk("strict_dut_seq", gseq[i], exp_st[i]);
        chk("strict_model_seq", mseq[i], exp_st[i]);
      end

    // Gap insertion: 5 gap cycles -> 6 idle cycles between packets
    fixed_len = 2; strict_v = 1'b0; gap_v = 16'd5; do_reset();
    repeat (40) step();
    chk("gap_count", runs.size() >= 2, 1'b1);
    if (runs.size() >= 2) begin
      chk("gap_run0", runs[0], 6);
      chk("gap_run1", runs[1], 6);
    end

    // Pause asserting mid-packet, then released, then an unmasked priority
    fixed_len = 4; gap_v = 16'd0; mask_v = 8'h08; vprob = '{100, 0}; do_reset();
    repeat (2) step();
    pause_v = 8'h08;
    repeat (3) step();
    repeat (8) step();
    chk("pause_pkt_done", tlast_cnt, 1);
    chk("pause_blocked", grant, 2'b00);
    pause_v = 8'h00;
    step();
    chk("unpause_idle", grant, 2'b00);
    step();
    chk("unpause_grant", grant, 2'b01);
    pause_v = 8'h04; t0 = tlast_cnt;
    repeat (20) step();
    chk("pause_unmasked", (tlast_cnt - t0) >= 3, 1'b1);
    pause_v = 8'h00;

    // Backpressure 1010 during a 4-beat packet
    vprob = '{100, 100}; ready_mode = 1; tog = 1'b1; do_reset();
    repeat (12) step();
    chk("bp_beats", outq.size() >= 4, 1'b1);
    if (outq.size() >= 4)
      for (int b = 0; b < 4; b++) chk("bp_order", outq[b], beat_data(0, 0, b));
    ready_mode = 0;

    // Reset during beat 2 of a packet
    do_reset();
    repeat (3) step();
    @(posedge clk);
    #1 drive();
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_tready", {s0_tready, s1_tready}, 2'b00);
    chk("rst_mid_busy", tx_busy, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();
    step();
    chk("rst_rr_ptr", grant, 2'b01);

    // Randomised traffic with configuration churn
    fixed_len = 0; rand_cfg = 1; do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      vprob[0] = int'($urandom_range(20, 100));
      vprob[1] = int'($urandom_range(20, 100));
      rprob    = int'($urandom_range(40, 100));
      repeat (200) step();
    end
    chk("rand_traffic", tlast_cnt > 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
